sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: KSEG_MAP, 1, when 1 addresses 0x8000_0000-0xBFFF_FFFF are translated by clearing addr[31:29].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 inst_sram_en / inst_sram_wen / inst_sram_addr / inst_sram_wdata  in  1/4/32/32  core instruction-fetch request.
REQ-005 inst_sram_rdata  out  32  fetched instruction returned to core.
REQ-006 data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata  in  1/4/32/32  core load/store request.
REQ-007 data_sram_rdata  out  32  load data returned to core.
REQ-008 stallreq  out  1  to CTRL; high freezes the whole pipeline.
REQ-009 mem_req / mem_wr / mem_wstrb / mem_addr / mem_wdata  out  1/1/4/32/32  shared external sram-like request.
REQ-010 mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  external address accept, data return, read data.

Function
REQ-011 States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE; one-hot or binary, designer's choice.
REQ-012 IDLE: data_sram_en=1 -> D_REQ; else inst_sram_en=1 -> I_REQ; else stay.
REQ-013 stallreq = 1 combinationally in IDLE when either en=1, and in D_REQ, D_WAIT, I_REQ, I_WAIT; 0 in DONE and idle-without-request.
REQ-014 D_REQ: mem_req=1, mem_wr=|data_sram_wen, mem_wstrb=data_sram_wen, mem_addr=translated data_sram_addr, mem_wdata=data_sram_wdata; on mem_addr_ok -> D_WAIT.
REQ-015 D_WAIT: mem_req=0; on mem_data_ok capture mem_rdata into data rdata register (reads only; writes leave register unchanged); then inst_sram_en latched high -> I_REQ, else -> DONE.
REQ-016 I_REQ/I_WAIT: same as REQ-014/015 with inst_sram_* signals, mem_wr=0, mem_wstrb=0; capture into inst rdata register; I_WAIT on mem_data_ok -> DONE.
REQ-017 inst_sram_en and data_sram_en sampled in IDLE are latched; latched flags, not live inputs, decide the I_REQ branch.
REQ-018 DONE lasts exactly one cycle, stallreq=0, then -> IDLE; new requests are not issued in DONE.
REQ-019 inst_sram_rdata/data_sram_rdata driven from registers; stable from capture until the next capture of the same register.
REQ-020 mem_addr_ok and mem_data_ok in the same cycle in D_REQ/I_REQ: treat as address accepted only; data_ok counted in the WAIT state only.
REQ-021 mem_data_ok outside a WAIT state is ignored.
REQ-022 mem_req deasserted in every state except D_REQ/I_REQ; request fields hold stable while mem_req=1 and mem_addr_ok=0.
REQ-023 Translation: KSEG_MAP=1 and addr[31:30]==2'b10 -> {3'b000, addr[28:0]}; otherwise pass-through.
REQ-024 Latency with zero-wait memory: instruction-only 4 cycles IDLE->DONE exit; data+instruction 6 cycles.

Reset
REQ-025 rst=1 forces IDLE immediately, clears latched flags and both rdata registers to 0, mem_req=0, stallreq=0 for the duration of rst.
REQ-026 rst asserted mid-transaction abandons it; a later mem_data_ok from that transaction is ignored per REQ-021.

Structure
REQ-027 State encodings and KSEG_MAP-related address constants live in lib/defines.vh.
REQ-028 Address translation is a natural sub-module: addr_map (combinational, instanced twice or muxed once).
REQ-029 Integrates into mycpu_core between the IF/EX SRAM ports and the top-level memory port; stallreq ORs into CTRL.

Verification
REQ-030 Fetch only, inst_addr=0xBFC0_0000, memory returns 0x2408_0001 with addr_ok/data_ok immediate -> mem_addr=0x1FC0_0000, stallreq high 3 cycles, inst_sram_rdata=0x2408_0001 in DONE.
REQ-031 Load+fetch same cycle, data_addr=0x8000_0010 -> data request first (mem_addr=0x0000_0010, mem_wr=0), then instruction; both rdata registers correct in DONE.
REQ-032 Store wen=4'b0011 wdata=0xDEAD_BEEF with addr_ok delayed 5 cycles -> mem_req held with stable fields, mem_wstrb=0011, data_sram_rdata unchanged.
REQ-033 KSEG_MAP=0, addr 0x8000_0000 -> mem_addr=0x8000_0000.
REQ-034 rst pulsed in D_WAIT, stray data_ok after -> state IDLE, rdata registers 0, no capture.
REQ-035 addr_ok and data_ok same cycle in I_REQ -> no capture until a separate data_ok in I_WAIT.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: FSM state encodings and the kseg
// address window used by the optional address translation.
package sram_arbiter_pkg;

  // Binary FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_D_REQ  = 3'd1;
  localparam logic [2:0] ST_D_WAIT = 3'd2;
  localparam logic [2:0] ST_I_REQ  = 3'd3;
  localparam logic [2:0] ST_I_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // addr[31:30] of the unmapped kseg0/kseg1 window 0x8000_0000-0xBFFF_FFFF
  localparam logic [1:0] KSEG_TOP_BITS = 2'b10;
  // Bits cleared when an address falls inside that window
  localparam logic [2:0] KSEG_CLEAR_BITS = 3'b000;

  // Map a virtual kseg0/kseg1 address onto its physical alias.
  function automatic logic [31:0] kseg_translate(input logic [31:0] addr, input logic enable);
    logic [31:0] paddr;
    paddr = addr;
    if (enable && (addr[31:30] == KSEG_TOP_BITS)) begin
      paddr = {KSEG_CLEAR_BITS, addr[28:0]};
    end
    return paddr;
  endfunction

endpackage

// File: rtl/sram_arbiter_addr_map.sv
// Combinational virtual-to-physical address map for the arbiter's request ports.
module sram_arbiter_addr_map #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic [31:0] addr,
  output logic [31:0] paddr
);

  import sram_arbiter_pkg::*;

  // Pure function of the address; no state
  always_comb begin
    paddr = kseg_translate(addr, KSEG_MAP);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the core's instruction-fetch and load/store SRAM ports onto one
// shared sram-like memory port. Data requests go first, the pipeline is held
// with stallreq for the whole transaction, and results are returned from
// registers that hold their value until the next capture.
module sram_arbiter #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,

  output logic        stallreq,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  import sram_arbiter_pkg::*;

  logic [2:0]  state_q, state_d;
  logic        inst_en_q, data_en_q;
  logic [3:0]  data_wen_q;
  logic [31:0] data_addr_q, data_wdata_q, inst_addr_q;
  logic [31:0] data_rdata_q, inst_rdata_q;
  logic [31:0] data_paddr, inst_paddr;
  logic        latch_req;
  logic        data_capture;
  logic        inst_capture;
  logic        in_idle;

  // Instruction fetches never write; the write fields of that port are ignored
  logic unused_inst_write;
  assign unused_inst_write = ^{inst_sram_wen, inst_sram_wdata};

  sram_arbiter_addr_map #(
    .KSEG_MAP (KSEG_MAP)
  ) u_data_map (
    .addr  (data_sram_addr),
    .paddr (data_paddr)
  );

  sram_arbiter_addr_map #(
    .KSEG_MAP (KSEG_MAP)
  ) u_inst_map (
    .addr  (inst_sram_addr),
    .paddr (inst_paddr)
  );

  // Decode of the conditions that load request and response registers
  always_comb begin
    in_idle      = (state_q == ST_IDLE);
    latch_req    = in_idle && (inst_sram_en || data_sram_en);
    // Writes return no data, so the load register keeps its last value
    data_capture = (state_q == ST_D_WAIT) && mem_data_ok && !(|data_wen_q);
    // data_ok is only honoured in the WAIT states, so a same-cycle
    // addr_ok/data_ok in a REQ state counts as address accept only
    inst_capture = (state_q == ST_I_WAIT) && mem_data_ok;
  end

  // Next-state logic; the latched inst flag, not the live input, picks the
  // second leg of a combined load+fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_sram_en) begin
          state_d = ST_D_REQ;
        end else if (inst_sram_en) begin
          state_d = ST_I_REQ;
        end
      end
      ST_D_REQ: begin
        if (mem_addr_ok) begin
          state_d = ST_D_WAIT;
        end
      end
      ST_D_WAIT: begin
        if (mem_data_ok) begin
          state_d = inst_en_q ? ST_I_REQ : ST_DONE;
        end
      end
      ST_I_REQ: begin
        if (mem_addr_ok) begin
          state_d = ST_I_WAIT;
        end
      end
      ST_I_WAIT: begin
        if (mem_data_ok) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request snapshot taken in IDLE so fields stay stable while mem_req waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_en_q    <= 1'b0;
      data_en_q    <= 1'b0;
      data_wen_q   <= 4'b0000;
      data_addr_q  <= 32'h0;
      data_wdata_q <= 32'h0;
      inst_addr_q  <= 32'h0;
    end else if (latch_req) begin
      inst_en_q    <= inst_sram_en;
      data_en_q    <= data_sram_en;
      data_wen_q   <= data_sram_wen;
      data_addr_q  <= data_paddr;
      data_wdata_q <= data_sram_wdata;
      inst_addr_q  <= inst_paddr;
    end
  end

  // Load data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rdata_q <= 32'h0;
    end else if (data_capture) begin
      data_rdata_q <= mem_rdata;
    end
  end

  // Instruction data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= 32'h0;
    end else if (inst_capture) begin
      inst_rdata_q <= mem_rdata;
    end
  end

  // Memory-port request fields, driven only in the REQ states
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state_q)
      ST_D_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = |data_wen_q;
        mem_wstrb = data_wen_q;
        mem_addr  = data_addr_q;
        mem_wdata = data_wdata_q;
      end
      ST_I_REQ: begin
        mem_req  = 1'b1;
        mem_addr = inst_addr_q;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Stall from the first IDLE cycle that sees a request until DONE; the
  // rst term keeps it low while reset is held even with requests pending
  always_comb begin
    stallreq = 1'b0;
    case (state_q)
      ST_IDLE:   stallreq = inst_sram_en || data_sram_en;
      ST_D_REQ:  stallreq = 1'b1;
      ST_D_WAIT: stallreq = 1'b1;
      ST_I_REQ:  stallreq = 1'b1;
      ST_I_WAIT: stallreq = 1'b1;
      default:   stallreq = 1'b0;
    endcase
    if (rst) begin
      stallreq = 1'b0;
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  // data_en_q only records what was sampled; the data leg is chosen live in IDLE
  logic unused_data_flag;
  assign unused_data_flag = data_en_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. A second instance with KSEG_MAP=0 shares
// all inputs so the untranslated address path can be compared side by side.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic [31:0] nm_inst_sram_rdata;
  logic [31:0] nm_data_sram_rdata;
  logic        nm_stallreq;
  logic        nm_mem_req;
  logic        nm_mem_wr;
  logic [3:0]  nm_mem_wstrb;
  logic [31:0] nm_mem_addr;
  logic [31:0] nm_mem_wdata;

  int n_cmp;
  int n_bad;

  sram_arbiter #(.KSEG_MAP(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  sram_arbiter #(.KSEG_MAP(1'b0)) dut_nomap (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (nm_inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (nm_data_sram_rdata),
    .stallreq        (nm_stallreq),
    .mem_req         (nm_mem_req),
    .mem_wr          (nm_mem_wr),
    .mem_wstrb       (nm_mem_wstrb),
    .mem_addr        (nm_mem_addr),
    .mem_wdata       (nm_mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    inst_sram_en = 1'b1;
    data_sram_en = 1'b1;
    step;
    step;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (inst_sram_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_inst_rdata: got %h want 0", inst_sram_rdata); end
    n_cmp++; if (data_sram_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_data_rdata: got %h want 0", data_sram_rdata); end
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_fetch;
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL fetch_idle_stall: got %b want 1", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_req: got %b want 0", mem_req); end
    step;  // I_REQ
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h1FC0_0000) begin n_bad++; $display("FAIL fetch_addr: got %h want 1fc00000", mem_addr); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL fetch_wr: got %b want 0", mem_wr); end
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL fetch_req_stall: got %b want 1", stallreq); end
    step;  // I_WAIT
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h2408_0001;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_wait_req: got %b want 0", mem_req); end
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL fetch_wait_stall: got %b want 1", stallreq); end
    step;  // DONE
    mem_data_ok = 1'b0;
    inst_sram_en = 1'b0;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL fetch_done_stall: got %b want 0", stallreq); end
    n_cmp++; if (inst_sram_rdata !== 32'h2408_0001) begin n_bad++; $display("FAIL fetch_rdata: got %h want 24080001", inst_sram_rdata); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_done_req: got %b want 0", mem_req); end
    step;  // IDLE
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_after: got %b want 0", stallreq); end
  endtask

  task automatic test_load_fetch;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h8000_0010;
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0004;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL lf_idle_stall: got %b want 1", stallreq); end
    step;  // D_REQ; live enables drop, latched flags must carry on
    data_sram_en = 1'b0;
    inst_sram_en = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL lf_dreq: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL lf_daddr: got %h want 00000010", mem_addr); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL lf_dwr: got %b want 0", mem_wr); end
    step;  // D_WAIT
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h1111_2222;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL lf_dwait_req: got %b want 0", mem_req); end
    step;  // I_REQ
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL lf_ireq: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h1FC0_0004) begin n_bad++; $display("FAIL lf_iaddr: got %h want 1fc00004", mem_addr); end
    n_cmp++; if (mem_wstrb !== 4'b0000) begin n_bad++; $display("FAIL lf_iwstrb: got %b want 0000", mem_wstrb); end
    step;  // I_WAIT
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h3333_4444;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL lf_iwait_stall: got %b want 1", stallreq); end
    step;  // DONE
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL lf_done_stall: got %b want 0", stallreq); end
    n_cmp++; if (data_sram_rdata !== 32'h1111_2222) begin n_bad++; $display("FAIL lf_drdata: got %h want 11112222", data_sram_rdata); end
    n_cmp++; if (inst_sram_rdata !== 32'h3333_4444) begin n_bad++; $display("FAIL lf_irdata: got %h want 33334444", inst_sram_rdata); end
    step;  // IDLE
  endtask

  task automatic test_store_delay;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0011;
    data_sram_addr = 32'h8000_0020;
    data_sram_wdata = 32'hDEAD_BEEF;
    #1;
    step;  // D_REQ
    data_sram_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL st_req[%0d]: got %b want 1", i, mem_req); end
      n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL st_wr[%0d]: got %b want 1", i, mem_wr); end
      n_cmp++; if (mem_wstrb !== 4'b0011) begin n_bad++; $display("FAIL st_wstrb[%0d]: got %b want 0011", i, mem_wstrb); end
      n_cmp++; if (mem_addr !== 32'h0000_0020) begin n_bad++; $display("FAIL st_addr[%0d]: got %h want 00000020", i, mem_addr); end
      n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_wdata[%0d]: got %h want deadbeef", i, mem_wdata); end
      step;
    end
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL st_req_accept: got %b want 1", mem_req); end
    step;  // D_WAIT
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step;  // DONE
    mem_data_ok = 1'b0;
    data_sram_wen = 4'b0000;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL st_done_stall: got %b want 0", stallreq); end
    n_cmp++; if (data_sram_rdata !== 32'h1111_2222) begin n_bad++; $display("FAIL st_rdata_kept: got %h want 11112222", data_sram_rdata); end
    step;  // IDLE
  endtask

  task automatic test_no_kseg;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h8000_0000;
    #1;
    step;  // D_REQ
    data_sram_en = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    n_cmp++; if (mem_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL nk_mapped_addr: got %h want 00000000", mem_addr); end
    n_cmp++; if (nm_mem_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL nk_unmapped_addr: got %h want 80000000", nm_mem_addr); end
    step;  // D_WAIT
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    step;  // DONE
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (data_sram_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL nk_rdata: got %h want 0badf00d", data_sram_rdata); end
    n_cmp++; if (nm_data_sram_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL nk_nm_rdata: got %h want 0badf00d", nm_data_sram_rdata); end
    step;  // IDLE
  endtask

  task automatic test_same_cycle;
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'h0000_1000;
    #1;
    step;  // I_REQ
    inst_sram_en = 1'b0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    #1;
    n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL sc_addr: got %h want 00001000", mem_addr); end
    step;  // I_WAIT, nothing captured yet
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (inst_sram_rdata !== 32'h3333_4444) begin n_bad++; $display("FAIL sc_no_capture: got %h want 33334444", inst_sram_rdata); end
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL sc_wait_stall: got %b want 1", stallreq); end
    step;  // still I_WAIT
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL sc_wait_stall2: got %b want 1", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL sc_wait_req: got %b want 0", mem_req); end
    mem_data_ok = 1'b1;
    mem_rdata = 32'h5555_6666;
    step;  // DONE
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (inst_sram_rdata !== 32'h5555_6666) begin n_bad++; $display("FAIL sc_rdata: got %h want 55556666", inst_sram_rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL sc_done_stall: got %b want 0", stallreq); end
    step;  // IDLE; stray data_ok must be ignored
    mem_data_ok = 1'b1;
    mem_rdata = 32'hDEAD_0000;
    step;
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (inst_sram_rdata !== 32'h5555_6666) begin n_bad++; $display("FAIL sc_stray_inst: got %h want 55556666", inst_sram_rdata); end
    n_cmp++; if (data_sram_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL sc_stray_data: got %h want 0badf00d", data_sram_rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL sc_stray_stall: got %b want 0", stallreq); end
  endtask

  task automatic test_reset_mid;
    step;
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h8000_0040;
    #1;
    step;  // D_REQ
    data_sram_en = 1'b0;
    mem_addr_ok = 1'b1;
    step;  // D_WAIT
    mem_addr_ok = 1'b0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL rm_dwait_stall: got %b want 1", stallreq); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rm_rst_stall: got %b want 0", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_rst_req: got %b want 0", mem_req); end
    n_cmp++; if (data_sram_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rst_drdata: got %h want 0", data_sram_rdata); end
    n_cmp++; if (inst_sram_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rst_irdata: got %h want 0", inst_sram_rdata); end
    step;
    rst = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h7777_7777;
    step;
    mem_data_ok = 1'b0;
    #1;
    n_cmp++; if (data_sram_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_stray_drdata: got %h want 0", data_sram_rdata); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rm_stray_stall: got %b want 0", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_stray_req: got %b want 0", mem_req); end
    step;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL rm_idle_stall: got %b want 0", stallreq); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_idle_req: got %b want 0", mem_req); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    inst_sram_en = 1'b0;
    inst_sram_wen = 4'b0000;
    inst_sram_addr = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'b0000;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
    test_reset;
    test_fetch;
    test_load_fetch;
    test_store_delay;
    test_no_kseg;
    test_same_cycle;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
